// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: sequences IF/ID/EX/MEM/WB, decodes opcode into datapath strobes,
// and handles debug halt/single-step, sticky fault trapping and the retired-instruction count.
module multicycle_sequencer #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             mem_ready,
   input  logic             branch_taken,
   input  logic             halt_req,
   input  logic             step_req,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             reg_we,
   output logic             mem_re,
   output logic             mem_we,
   output logic [2:0]       state,
   output logic             halted,
   output logic [1:0]       fault_cause,
   output logic [CNT_W-1:0] instret
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   localparam logic [2:0] S_IF   = 3'd0;
   localparam logic [2:0] S_ID   = 3'd1;
   localparam logic [2:0] S_EX   = 3'd2;
   localparam logic [2:0] S_MEM  = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_HALT = 3'd5;
   localparam logic [2:0] S_TRAP = 3'd6;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] FC_ILLEGAL = 2'd1;
   localparam logic [1:0] FC_TIMEOUT = 2'd2;

   logic [2:0]        r_state;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [1:0]        r_fault;
   logic [CNT_W-1:0]  r_instret;

   logic       w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr, w_legal;
   logic       w_mem_state, w_timeout;
   logic [2:0] w_next;
   logic       w_ir_we, w_pc_we, w_reg_we, w_mem_re, w_mem_we, w_retire;
   logic [1:0] w_pc_sel;
   logic       w_set_fault;
   logic [1:0] w_fault_val;

   assign w_is_load   = (opcode == OP_LOAD);
   assign w_is_store  = (opcode == OP_STORE);
   assign w_is_branch = (opcode == OP_BRANCH);
   assign w_is_jal    = (opcode == OP_JAL);
   assign w_is_jalr   = (opcode == OP_JALR);
   assign w_legal     = (opcode == OP_R) || (opcode == OP_I) || w_is_load || w_is_store ||
                        w_is_branch || w_is_jal || w_is_jalr || (opcode == OP_LUI) ||
                        (opcode == OP_AUIPC);

   // The wait that would be the MEM_TIMEOUT-th consecutive miss traps instead of strobing.
   assign w_mem_state = (r_state == S_IF) || (r_state == S_MEM);
   assign w_timeout   = w_mem_state && !mem_ready &&
                        (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      w_next      = r_state;
      w_ir_we     = 1'b0;
      w_reg_we    = 1'b0;
      w_mem_re    = 1'b0;
      w_mem_we    = 1'b0;
      w_retire    = 1'b0;
      w_pc_sel    = 2'd0;
      w_set_fault = 1'b0;
      w_fault_val = 2'd0;
      case (r_state)
         S_IF: begin
            if (w_timeout) begin
               w_next      = S_TRAP;
               w_set_fault = 1'b1;
               w_fault_val = FC_TIMEOUT;
            end else begin
               w_mem_re = 1'b1;
               if (mem_ready) begin
                  w_ir_we = 1'b1;
                  w_next  = S_ID;
               end
            end
         end
         S_ID: begin
            if (!w_legal) begin
               w_next      = S_TRAP;
               w_set_fault = 1'b1;
               w_fault_val = FC_ILLEGAL;
            end else begin
               w_next = S_EX;
            end
         end
         S_EX: begin
            if (w_is_load || w_is_store) begin
               w_next = S_MEM;
            end else if (w_is_branch) begin
               w_retire = 1'b1;
               w_pc_sel = {1'b0, branch_taken};
            end else begin
               w_next = S_WB;
            end
         end
         S_MEM: begin
            if (w_timeout) begin
               w_next      = S_TRAP;
               w_set_fault = 1'b1;
               w_fault_val = FC_TIMEOUT;
            end else if (w_is_store) begin
               w_mem_we = 1'b1;
               w_retire = mem_ready;
            end else begin
               w_mem_re = 1'b1;
               if (mem_ready) w_next = S_WB;
            end
         end
         S_WB: begin
            w_reg_we = 1'b1;
            w_retire = 1'b1;
            w_pc_sel = w_is_jal ? 2'd2 : (w_is_jalr ? 2'd3 : 2'd0);
         end
         S_HALT: begin
            if (step_req || !halt_req) w_next = S_IF;
         end
         S_TRAP: w_next = S_TRAP;
         default: w_next = S_IF;
      endcase
      w_pc_we = w_retire;
      if (w_retire) w_next = halt_req ? S_HALT : S_IF;
   end

   // Strobes are gated by rst so a reset cycle never writes anything, even mid-instruction.
   assign ir_we       = rst & w_ir_we;
   assign pc_we       = rst & w_pc_we;
   assign reg_we      = rst & w_reg_we;
   assign mem_re      = rst & w_mem_re;
   assign mem_we      = rst & w_mem_we;
   assign pc_sel      = rst ? w_pc_sel : 2'd0;
   assign state       = r_state;
   assign halted      = (r_state == S_HALT);
   assign fault_cause = r_fault;
   assign instret     = r_instret;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IF;
         r_wait_cnt <= '0;
         r_fault    <= 2'd0;
         r_instret  <= '0;
      end else begin
         r_state <= w_next;
         if (w_mem_state && !mem_ready && (w_next == r_state))
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
         else
            r_wait_cnt <= '0;
         if (w_set_fault) r_fault <= w_fault_val;
         if (w_retire)    r_instret <= r_instret + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: directed instructions push expected retire records,
// a negedge monitor pops them on every pc_we and compares.
module tb_multicycle_sequencer;

   localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4,
                          S_HALT = 3'd5, S_TRAP = 3'd6;
   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                          OP_STORE = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [6:0]  opcode = OP_R;
   logic        mem_ready = 1'b0;
   logic        branch_taken = 1'b0;
   logic        halt_req = 1'b0;
   logic        step_req = 1'b0;
   logic        ir_we, pc_we, reg_we, mem_re, mem_we, halted;
   logic [1:0]  pc_sel, fault_cause;
   logic [2:0]  state;
   logic [31:0] instret;

   multicycle_sequencer #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .branch_taken(branch_taken), .halt_req(halt_req), .step_req(step_req),
      .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .mem_re(mem_re),
      .mem_we(mem_we), .state(state), .halted(halted), .fault_cause(fault_cause),
      .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] pc_sel;
      logic [2:0] st;
      int         cyc;
      int         re;
      int         rwe;
      int         mwe;
      int         ir;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   lat_if = 0;
   int   lat_mem = 0;
   int   exp_ret = 0;

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Memory responder: mem_ready rises after lat_if / lat_mem wait cycles in IF / MEM.
   initial begin
      int wcnt = 0;
      int lat;
      forever begin
         @(posedge clk); #1;
         if (state == S_IF || state == S_MEM) begin
            lat = (state == S_IF) ? lat_if : lat_mem;
            if (wcnt >= lat) begin
               mem_ready = 1'b1;
               wcnt = 0;
            end else begin
               mem_ready = 1'b0;
               wcnt++;
            end
         end else begin
            mem_ready = 1'b0;
            wcnt = 0;
         end
      end
   end

   // Monitor: accumulates per-instruction activity and checks each retire against the scoreboard.
   initial begin
      int cyc = 0, re = 0, rwe = 0, mwe = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         check("strobe_exclusive", (int'(reg_we) + int'(mem_we) + int'(ir_we)) <= 1, 1);
         if (!rst) begin
            cyc = 0; re = 0; rwe = 0; mwe = 0;
         end else begin
            if (state != S_HALT && state != S_TRAP) begin
               cyc++;
               re  += int'(mem_re);
               rwe += int'(reg_we);
               mwe += int'(mem_we);
            end
            if (pc_we) begin
               check("retire_expected", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  check("ret_pc_sel", pc_sel, e.pc_sel);
                  check("ret_state", state, e.st);
                  check("ret_cycles", cyc, e.cyc);
                  check("ret_mem_re_cycles", re, e.re);
                  check("ret_reg_we_cycles", rwe, e.rwe);
                  check("ret_mem_we_cycles", mwe, e.mwe);
                  check("ret_instret", instret, e.ir);
               end
               cyc = 0; re = 0; rwe = 0; mwe = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) begin
         @(negedge clk); #1;
      end
      check("drain_queue_empty", sb.size(), 0);
      sb.delete();
   endtask

   task automatic push(input logic [1:0] ps, input logic [2:0] st, input int cyc, input int re,
                       input int rwe, input int mwe);
      exp_t e;
      e.pc_sel = ps; e.st = st; e.cyc = cyc; e.re = re; e.rwe = rwe; e.mwe = mwe;
      e.ir = exp_ret;
      exp_ret++;
      sb.push_back(e);
   endtask

   task automatic run(input logic [6:0] op, input int li, input int lm, input logic bt,
                      input logic [1:0] ps, input logic [2:0] st, input int cyc, input int re,
                      input int rwe, input int mwe);
      lat_if = li;
      tick();
      opcode = op;
      lat_mem = lm;
      branch_taken = bt;
      push(ps, st, cyc, re, rwe, mwe);
      drain();
   endtask

   task automatic reset_and_check(input string tag);
      tick();
      rst = 1'b0;
      tick();
      tick();
      @(negedge clk); #1;
      check({tag, "_state"}, state, S_IF);
      check({tag, "_fault"}, fault_cause, 0);
      check({tag, "_instret"}, instret, 0);
      check({tag, "_mem_re_gated"}, mem_re, 0);
      check({tag, "_halted"}, halted, 0);
      exp_ret = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, nbad;
      logic last_re;

      reset_and_check("reset");
      opcode = OP_R;
      tick();
      rst = 1'b1;
      drain();

      // R-type: run starts after first drain, so issue explicitly from reset release.
      //        op        li lm bt  pc_sel st     cyc re rwe mwe
      run(OP_R,     0, 0, 1'b0, 2'd0, S_WB,  4, 1, 1, 0);
      run(OP_I,     0, 0, 1'b0, 2'd0, S_WB,  4, 1, 1, 0);
      run(OP_LOAD,  0, 3, 1'b0, 2'd0, S_WB,  8, 5, 1, 0);
      run(OP_STORE, 0, 2, 1'b0, 2'd0, S_MEM, 6, 1, 0, 3);
      run(OP_BR,    0, 0, 1'b1, 2'd1, S_EX,  3, 1, 0, 0);
      run(OP_BR,    0, 0, 1'b0, 2'd0, S_EX,  3, 1, 0, 0);
      run(OP_LUI,   2, 0, 1'b0, 2'd0, S_WB,  6, 3, 1, 0);
      run(OP_JALR,  0, 0, 1'b0, 2'd3, S_WB,  4, 1, 1, 0);

      // jal with halt_req held: retires then halts.
      lat_if = 0;
      tick();
      opcode = OP_JAL;
      halt_req = 1'b1;
      push(2'd2, S_WB, 4, 1, 1, 0);
      drain();
      repeat (5) @(negedge clk);
      #1;
      check("halt_state", state, S_HALT);
      check("halt_flag", halted, 1);
      check("halt_strobes", {ir_we, pc_we, reg_we, mem_re, mem_we}, 0);
      check("halt_instret", instret, exp_ret);

      // Single step: exactly one instruction, then back in HALT.
      opcode = OP_R;
      push(2'd0, S_WB, 4, 1, 1, 0);
      tick();
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      drain();
      repeat (3) @(negedge clk);
      #1;
      check("step_rehalt_state", state, S_HALT);
      check("step_instret", instret, exp_ret);

      // Release halt.
      tick();
      opcode = OP_I;
      push(2'd0, S_WB, 4, 1, 1, 0);
      halt_req = 1'b0;
      drain();

      // Illegal opcode: IF, ID, then sticky TRAP.
      lat_if = 0;
      tick();
      opcode = OP_BAD;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (state == S_TRAP) break;
         n++;
      end
      check("illegal_cycles_to_trap", n, 2);
      check("illegal_fault", fault_cause, 1);
      nbad = 0;
      for (int i = 0; i < 25; i++) begin
         halt_req = i[0];
         step_req = i[1];
         @(negedge clk); #1;
         if (state != S_TRAP || fault_cause != 2'd1 || halted ||
             {ir_we, pc_we, reg_we, mem_re, mem_we} != 5'd0)
            nbad++;
      end
      halt_req = 1'b0;
      step_req = 1'b0;
      check("trap_sticky_bad_cycles", nbad, 0);
      check("trap_instret", instret, exp_ret);

      // Reset clears the trap; then abort a load in MEM with reset.
      reset_and_check("trap_reset");
      opcode = OP_LOAD;
      lat_mem = 1000;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 20 && state != S_MEM; i++) begin
         @(negedge clk); #1;
      end
      check("abort_in_mem", state, S_MEM);
      check("abort_mem_re_before", mem_re, 1);
      rst = 1'b0;
      #1;
      check("abort_mem_re_in_reset", {ir_we, pc_we, reg_we, mem_re, mem_we}, 0);
      tick();
      @(negedge clk); #1;
      check("abort_state", state, S_IF);
      check("abort_instret", instret, 0);

      // Fetch timeout: mem_ready never arrives in IF.
      lat_if = 1000;
      tick();
      rst = 1'b1;
      n = 0;
      last_re = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (state == S_TRAP) break;
         n++;
         last_re = mem_re;
      end
      check("timeout_if_cycles", n, 16);
      check("timeout_last_mem_re", last_re, 0);
      check("timeout_state", state, S_TRAP);
      check("timeout_fault", fault_cause, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
